// File: rtl/tc0480scp_rom_cache_pkg.sv
// -----------------------------------------------------------------------------
// tc0480scp_pkg
// Shared types and constants for the TC0480SCP tile-ROM cache.
//   rom_cache_state_t : controller states (IDLE, LOOKUP, FILL)
//   ROM_WORD_BYTES    : bytes per cached ROM word (one 64-bit word)
//   ROM_WA_BITS       : width of the ROM word address (rom_address[20:3])
// -----------------------------------------------------------------------------
package tc0480scp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        FILL   = 2'd2
    } rom_cache_state_t;

    localparam int ROM_WORD_BYTES = 8;
    localparam int ROM_WA_BITS    = 18;

endpackage

// File: rtl/tc0480scp_rom_cache_ram.sv
// -----------------------------------------------------------------------------
// tc0480scp_rom_cache_ram
// Single-port synchronous RAM holding {tag, data} per cache line.
// Read data appears one cycle after the address is presented; a write
// updates the addressed word and the read port returns the old contents.
// Ports:
//   clk      in   clock
//   i_we     in   write enable
//   i_addr   in   line index
//   i_wdata  in   {tag, data} to write
//   o_rdata  out  registered {tag, data} read from i_addr
// -----------------------------------------------------------------------------
module tc0480scp_rom_cache_ram #(
    parameter int INDEX_BITS = 6,
    parameter int WIDTH      = 76
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [INDEX_BITS-1:0] i_addr,
    input  logic [WIDTH-1:0]      i_wdata,
    output logic [WIDTH-1:0]      o_rdata
);

    logic [WIDTH-1:0] r_mem [2**INDEX_BITS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        o_rdata <= r_mem[i_addr];
    end

endmodule

// File: rtl/tc0480scp_rom_cache.sv
// -----------------------------------------------------------------------------
// tc0480scp_rom_cache
// Direct-mapped cache of 64-bit tile-ROM words between the TC0480SCP ROM port
// and the SDRAM graphics channel. Both sides use toggle handshakes (a request
// is pending while req != ack).
// Optional feature macro: TC0480SCP_ROM_CACHE_STATS_EN adds saturating
// hit_count / miss_count outputs, cleared by reset or flush.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   flush           one-cycle pulse, invalidates every line
//   rom_address     client byte address (bits [2:0] ignored)
//   rom_req/rom_ack client toggle handshake, rom_data valid when equal
//   mem_addr        SDRAM byte address (MEM_BASE + word offset, 8-byte aligned)
//   mem_req/mem_ack SDRAM toggle handshake, mem_data valid when ack matches
//   hit_count, miss_count (stats build only)
// -----------------------------------------------------------------------------
module tc0480scp_rom_cache
    import tc0480scp_pkg::*;
#(
    parameter int          INDEX_BITS = 6,
    parameter logic [26:0] MEM_BASE   = 27'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic [20:0] rom_address,
    input  logic        rom_req,
    output logic        rom_ack,
    output logic [63:0] rom_data,
    output logic [26:0] mem_addr,
    output logic        mem_req,
    input  logic        mem_ack,
    input  logic [63:0] mem_data
`ifdef TC0480SCP_ROM_CACHE_STATS_EN
    ,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
`endif
);

    localparam int TAG_BITS = ROM_WA_BITS - INDEX_BITS;
    localparam int RAM_W    = TAG_BITS + 64;

    rom_cache_state_t             r_state;
    rom_cache_state_t             w_next_state;
    logic [ROM_WA_BITS-1:0]       r_wa;
    logic [2**INDEX_BITS-1:0]     r_valid;
    logic                         r_no_alloc;

    logic [INDEX_BITS-1:0]        w_idx;
    logic [RAM_W-1:0]             w_rdata;
    logic                         w_pending;
    logic                         w_hit;
    logic                         w_fill_done;
    logic [26:0]                  w_byte_addr;
    logic                         w_unused;

    // Byte-within-word bits never select anything.
    assign w_unused    = ^rom_address[2:0];

    assign w_pending   = (rom_req != rom_ack);
    // In IDLE the RAM is addressed straight from the client so the read
    // completes by the LOOKUP cycle; afterwards the latched index holds it.
    assign w_idx       = (r_state == IDLE) ? rom_address[3 +: INDEX_BITS]
                                           : r_wa[INDEX_BITS-1:0];
    // A flush in the LOOKUP cycle forces a miss.
    assign w_hit       = r_valid[r_wa[INDEX_BITS-1:0]] && !flush &&
                         (w_rdata[64 +: TAG_BITS] == r_wa[ROM_WA_BITS-1:INDEX_BITS]);
    assign w_fill_done = (r_state == FILL) && (mem_ack == mem_req);
    assign w_byte_addr = {6'b0, r_wa, 3'b000};

    tc0480scp_rom_cache_ram #(
        .INDEX_BITS (INDEX_BITS),
        .WIDTH      (RAM_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_fill_done),
        .i_addr  (w_idx),
        .i_wdata ({r_wa[ROM_WA_BITS-1:INDEX_BITS], mem_data}),
        .o_rdata (w_rdata)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_pending)   w_next_state = LOOKUP;
            LOOKUP:  w_next_state = w_hit ? IDLE : FILL;
            FILL:    if (w_fill_done) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_wa       <= '0;
            r_valid    <= '0;
            r_no_alloc <= 1'b0;
            rom_ack    <= 1'b0;
            rom_data   <= '0;
            mem_addr   <= '0;
            mem_req    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    if (w_pending) r_wa <= rom_address[20:3];
                end
                LOOKUP: begin
                    if (w_hit) begin
                        rom_data <= w_rdata[63:0];
                        rom_ack  <= rom_req;
                    end else begin
                        // 27-bit add, carry out deliberately dropped.
                        mem_addr <= MEM_BASE + w_byte_addr;
                        mem_req  <= ~mem_req;
                    end
                end
                FILL: begin
                    if (w_fill_done) begin
                        rom_data <= mem_data;
                        rom_ack  <= rom_req;
                    end
                end
                default: ;
            endcase

            // Flush wins over a same-cycle allocation.
            if (flush) begin
                r_valid <= '0;
            end else if (w_fill_done && !r_no_alloc) begin
                r_valid[r_wa[INDEX_BITS-1:0]] <= 1'b1;
            end

            // A flush seen during FILL must keep the in-flight line unallocated.
            if (r_state != FILL || w_fill_done) begin
                r_no_alloc <= 1'b0;
            end else if (flush) begin
                r_no_alloc <= 1'b1;
            end
        end
    end

`ifdef TC0480SCP_ROM_CACHE_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (flush) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (r_state == LOOKUP) begin
            if (w_hit) hit_count  <= sat_inc(hit_count);
            else       miss_count <= sat_inc(miss_count);
        end
    end
`endif

endmodule

// File: tb/tb_tc0480scp_rom_cache.sv
// -----------------------------------------------------------------------------
// tb_tc0480scp_rom_cache
// Bench for the TC0480SCP ROM cache: directed vector table, hand-written
// reset/stats sequences, and randomized traffic against a line-level model.
// The SDRAM side is a behavioural responder with programmable latency whose
// data is a fixed function of the requested address.
// -----------------------------------------------------------------------------
module tb_tc0480scp_rom_cache;

    localparam logic [26:0] BASE = 27'h0400000;

    logic        clk;
    logic        reset;
    logic        flush;
    logic [20:0] rom_address;
    logic        rom_req;
    logic        rom_ack;
    logic [63:0] rom_data;
    logic [26:0] mem_addr;
    logic        mem_req;
    logic        mem_ack;
    logic [63:0] mem_data;
`ifdef TC0480SCP_ROM_CACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    tc0480scp_rom_cache #(
        .INDEX_BITS (6),
        .MEM_BASE   (BASE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .rom_address (rom_address),
        .rom_req     (rom_req),
        .rom_ack     (rom_ack),
        .rom_data    (rom_data),
        .mem_addr    (mem_addr),
        .mem_req     (mem_req),
        .mem_ack     (mem_ack),
        .mem_data    (mem_data)
`ifdef TC0480SCP_ROM_CACHE_STATS_EN
        ,
        .hit_count   (hit_count),
        .miss_count  (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // SDRAM contents as a function of byte address.
    function automatic logic [63:0] data_of(input logic [26:0] a);
        if (a == 27'h0401238) return 64'hDEADBEEF_01234567;
        return {a ^ 27'h5A5A5A5, 10'h3C5, a};
    endfunction

    // ---------------- SDRAM responder ----------------
    int          sd_lat = 5;
    int          mem_txn = 0;
    int          addr_unstable = 0;
    logic [26:0] sd_addr;

    initial begin : sdram
        bit busy;
        int cnt;
        busy = 0;
        cnt = 0;
        sd_addr = '0;
        mem_ack = 1'b0;
        mem_data = '0;
        forever begin
            @(posedge clk); #2;
            if (reset) begin
                mem_ack = 1'b0;
                busy = 0;
            end else if (mem_req != mem_ack) begin
                if (!busy) begin
                    busy = 1;
                    cnt = 0;
                    sd_addr = mem_addr;
                    mem_txn++;
                end else begin
                    cnt++;
                    if (mem_addr != sd_addr) addr_unstable++;
                end
                if (cnt >= sd_lat) begin
                    mem_data = data_of(sd_addr);
                    mem_ack = mem_req;
                    busy = 0;
                end
            end
        end
    end

    // ---------------- reference model: one remembered word address per line ----
    bit [63:0]   model_valid;
    logic [17:0] model_wa [64];

    function automatic logic model_hit(input logic [20:0] addr);
        logic [17:0] wa;
        wa = addr[20:3];
        return model_valid[wa[5:0]] && (model_wa[wa[5:0]] == wa);
    endfunction

    // Toggle rom_req, optionally pulse flush so it is high during edge flush_at+1,
    // and count edges until the ack toggles.
    task automatic do_req(input logic [20:0] addr, input int lat, input int flush_at,
                          output int ncyc, output int ntx);
        int tx0;
        sd_lat = lat;
        @(posedge clk); #1;
        tx0 = mem_txn;
        rom_address = addr;
        rom_req = ~rom_req;
        ncyc = 0;
        while (1) begin
            @(posedge clk); #1;
            ncyc++;
            flush = 1'b0;
            if (rom_ack == rom_req) break;
            if (ncyc == flush_at) flush = 1'b1;
            if (ncyc > 100) break;
        end
        flush = 1'b0;
        ntx = mem_txn - tx0;
    endtask

    task automatic txn(input string nm, input logic [20:0] addr, input int lat,
                       input int flush_at, input logic exp_hit, input logic [26:0] maddr);
        int n, tx;
        logic [17:0] wa;
        wa = addr[20:3];
        do_req(addr, lat, flush_at, n, tx);
        check({nm, ".latency"}, 64'(n), exp_hit ? 64'd2 : 64'(3 + lat));
        check({nm, ".memtxn"}, 64'(tx), exp_hit ? 64'd0 : 64'd1);
        check({nm, ".data"}, rom_data, data_of(maddr));
        if (!exp_hit) check({nm, ".mem_addr"}, {37'b0, mem_addr}, {37'b0, maddr});
        if (flush_at > 0) model_valid = '0;
        if (!exp_hit && flush_at <= 1) begin
            model_valid[wa[5:0]] = 1'b1;
            model_wa[wa[5:0]] = wa;
        end
    endtask

    task automatic pulse_flush();
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        model_valid = '0;
    endtask

    typedef struct {
        logic [20:0] addr;
        int          lat;
        int          flush_at;
        logic        hit;
        logic [26:0] maddr;
    } vec_t;

    vec_t tbl [15];

    initial begin
        tbl[0]  = '{21'h001238, 5, 0, 1'b0, 27'h0401238};  // cold miss
        tbl[1]  = '{21'h001238, 5, 0, 1'b1, 27'h0401238};  // hit
        tbl[2]  = '{21'h001438, 4, 0, 1'b0, 27'h0401438};  // same index, new tag
        tbl[3]  = '{21'h001238, 3, 0, 1'b0, 27'h0401238};  // evicted
        tbl[4]  = '{21'h00123F, 3, 0, 1'b1, 27'h0401238};  // low bits ignored
        tbl[5]  = '{21'h002000, 6, 4, 1'b0, 27'h0402000};  // flush mid-FILL
        tbl[6]  = '{21'h002000, 2, 0, 1'b0, 27'h0402000};  // not allocated
        tbl[7]  = '{21'h002000, 2, 0, 1'b1, 27'h0402000};
        tbl[8]  = '{21'h002000, 3, 1, 1'b0, 27'h0402000};  // flush in LOOKUP
        tbl[9]  = '{21'h002000, 3, 0, 1'b1, 27'h0402000};
        tbl[10] = '{21'h003000, 5, 7, 1'b0, 27'h0403000};  // flush on completion
        tbl[11] = '{21'h003000, 1, 0, 1'b0, 27'h0403000};
        tbl[12] = '{21'h1FFFF8, 2, 0, 1'b0, 27'h05FFFF8};  // top of ROM
        tbl[13] = '{21'h1FFFF8, 2, 0, 1'b1, 27'h05FFFF8};
        tbl[14] = '{21'h003000, 1, 0, 1'b1, 27'h0403000};

        reset = 1'b1;
        flush = 1'b0;
        rom_req = 1'b0;
        rom_address = '0;
        model_valid = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.rom_ack", {63'b0, rom_ack}, 64'd0);
        check("reset.rom_data", rom_data, 64'd0);
        check("reset.mem_req", {63'b0, mem_req}, 64'd0);
        check("reset.mem_addr", {37'b0, mem_addr}, 64'd0);
`ifdef TC0480SCP_ROM_CACHE_STATS_EN
        check("reset.hit_count", {48'b0, hit_count}, 64'd0);
        check("reset.miss_count", {48'b0, miss_count}, 64'd0);
`endif
        reset = 1'b0;

        check("cold.data_literal", data_of(27'h0401238), 64'hDEADBEEF_01234567);
        for (int i = 0; i < 15; i++) begin
            txn($sformatf("vec%0d", i), tbl[i].addr, tbl[i].lat, tbl[i].flush_at,
                tbl[i].hit, tbl[i].maddr);
        end

`ifdef TC0480SCP_ROM_CACHE_STATS_EN
        pulse_flush();
        check("stats.flush_hit", {48'b0, hit_count}, 64'd0);
        check("stats.flush_miss", {48'b0, miss_count}, 64'd0);
        txn("stats0", 21'h004440, 3, 0, 1'b0, 27'h0404440);
        for (int i = 1; i < 4; i++) txn("statsh", 21'h004440, 3, 0, 1'b1, 27'h0404440);
        check("stats.hit_count", {48'b0, hit_count}, 64'd3);
        check("stats.miss_count", {48'b0, miss_count}, 64'd1);
        pulse_flush();
        check("stats.clr_hit", {48'b0, hit_count}, 64'd0);
        check("stats.clr_miss", {48'b0, miss_count}, 64'd0);
`endif

        // Randomized traffic over a few heavily shared lines.
        for (int i = 0; i < 120; i++) begin
            logic [5:0]  idx;
            logic [11:0] tg;
            logic [20:0] a;
            logic [26:0] ma;
            idx = 6'($urandom_range(0, 3) * 13);
            tg  = 12'($urandom_range(0, 2));
            a   = {tg, idx, 3'($urandom_range(0, 7))};
            ma  = BASE + {6'b0, a[20:3], 3'b000};
            if ($urandom_range(0, 11) == 0) pulse_flush();
            txn("rnd", a, int'($urandom_range(1, 6)), 0, model_hit(a), ma);
        end

        // Reset in the middle of a fill.
        sd_lat = 20;
        @(posedge clk); #1;
        rom_address = 21'h005008;
        rom_req = ~rom_req;
        repeat (5) @(posedge clk);
        #1;
        check("rstfill.mem_req_issued", {63'b0, mem_req != mem_ack}, 64'd1);
        reset = 1'b1;
        rom_req = 1'b0;
        #1;
        check("rstfill.mem_req", {63'b0, mem_req}, 64'd0);
        check("rstfill.rom_ack", {63'b0, rom_ack}, 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_valid = '0;
        txn("after_rst", 21'h005008, 3, 0, 1'b0, 27'h0405008);
        txn("after_rst_hit", 21'h005008, 3, 0, 1'b1, 27'h0405008);

        check("mem_addr_stable", 64'(addr_unstable), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
